// File: rtl/img_pkg.sv
// Shared constants for the image-cleanup line: default geometry, token kinds
// and the fixed latency of the 3x3 median pipeline.
package img_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_COL   = 752;
    localparam int MED_LAT   = 4;

    typedef enum logic {
        TOK_BORDER = 1'b0,
        TOK_MEDIAN = 1'b1
    } tok_e;

endpackage

// File: rtl/sort3_reg.sv
// Registered three-input compare-exchange: sorts a/b/c into lo/mid/hi in one
// cycle and carries a valid bit alongside the sorted data.
module sort3_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mid,
    output logic [WIDTH-1:0] hi,
    output logic             vld_out
);

    logic [WIDTH-1:0] ab_lo, ab_hi, abc_t;

    // Three-exchange network: order a/b, pull the minimum against c, then
    // order the two survivors for mid/hi.
    always_comb begin
        ab_lo = (a < b) ? a : b;
        ab_hi = (a < b) ? b : a;
        abc_t = (ab_lo < c) ? c : ab_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_out <= 1'b0;
        else     vld_out <= vld_in;
    end

    always_ff @(posedge clk) begin
        lo  <= (ab_lo < c) ? ab_lo : c;
        mid <= (ab_hi < abc_t) ? ab_hi : abc_t;
        hi  <= (ab_hi < abc_t) ? abc_t : ab_hi;
    end

endmodule

// File: rtl/median_fix3x3.sv
// 3x3 median impulse-noise fix on three aligned row streams: the middle row's
// pixel is replaced by the neighbourhood median when it strays past THRESH.
module median_fix3x3
    import img_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int COL    = DEF_COL,
    parameter int THRESH = 0
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] row_top,
    input  logic [WIDTH-1:0] row_mid,
    input  logic [WIDTH-1:0] row_bot,
    input  logic             valid_in,
    output logic [WIDTH-1:0] dout,
    output logic             valid_out,
    output logic             fixed
);

    localparam int             CW   = (COL > 1) ? $clog2(COL) : 1;
    localparam logic [CW-1:0]  LAST = CW'(COL - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);
    localparam logic [WIDTH:0] THR  = (WIDTH + 1)'(THRESH);

    function automatic logic [WIDTH-1:0] min2(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return (x < y) ? x : y;
    endfunction

    function automatic logic [WIDTH-1:0] max2(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return (x < y) ? y : x;
    endfunction

    function automatic logic [WIDTH-1:0] med3(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic [WIDTH-1:0] z);
        return max2(min2(x, y), min2(max2(x, y), z));
    endfunction

    function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic signed [WIDTH+1:0] d;
        d = $signed({2'b00, x}) - $signed({2'b00, y});
        return (d < 0) ? WIDTH'(1) * 0 + (WIDTH + 1)'(-d) : (WIDTH + 1)'(d);
    endfunction

    logic [CW-1:0]    col_cnt;
    logic             tail;
    logic [WIDTH-1:0] win_p0 [3][3];
    logic             vld_p0, vld_p1, vld_p2, vld_p3;
    tok_e             kind_p0, kind_p1, kind_p2, kind_p3;
    logic [WIDTH-1:0] centre_p0, centre_p1, centre_p2, centre_p3;
    logic [WIDTH-1:0] lo_p1 [3];
    logic [WIDTH-1:0] mid_p1 [3];
    logic [WIDTH-1:0] hi_p1 [3];
    logic [2:0]       vld_s1;
    logic [WIDTH-1:0] lo_max_p2, mid_med_p2, hi_min_p2, med_p3;

    // E0: column counter, window shift and token launch. The centre is taken
    // from column 2 before the shift, which also serves the tail token while
    // a new row may already be loading.
    always_ff @(posedge clk) begin
        if (en) begin
            col_cnt <= '0;
            tail    <= 1'b0;
            vld_p0  <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    win_p0[r][k] <= '0;
        end else begin
            tail   <= valid_in && (col_cnt == LAST);
            vld_p0 <= tail || (valid_in && (col_cnt != '0));
            if (valid_in) begin
                col_cnt <= (col_cnt == LAST) ? '0 : col_cnt + ONE;
                for (int r = 0; r < 3; r++) begin
                    win_p0[r][0] <= win_p0[r][1];
                    win_p0[r][1] <= win_p0[r][2];
                end
                win_p0[0][2] <= row_top;
                win_p0[1][2] <= row_mid;
                win_p0[2][2] <= row_bot;
            end
        end
    end

    // S1: per-column sort
    for (genvar g = 0; g < 3; g++) begin : g_sort
        sort3_reg #(.WIDTH(WIDTH)) u_sort (
            .clk     (clk),
            .rst     (en),
            .vld_in  (vld_p0),
            .a       (win_p0[0][g]),
            .b       (win_p0[1][g]),
            .c       (win_p0[2][g]),
            .lo      (lo_p1[g]),
            .mid     (mid_p1[g]),
            .hi      (hi_p1[g]),
            .vld_out (vld_s1[g])
        );
    end

    assign vld_p1 = &vld_s1;

    always_ff @(posedge clk) begin
        if (en) begin
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (tail || valid_in) begin
            centre_p0 <= win_p0[1][2];
            kind_p0   <= (tail || col_cnt == ONE) ? TOK_BORDER : TOK_MEDIAN;
        end
        kind_p1   <= kind_p0;
        centre_p1 <= centre_p0;
        // S2: max of mins, median of mids, min of maxes
        lo_max_p2  <= max2(max2(lo_p1[0], lo_p1[1]), lo_p1[2]);
        mid_med_p2 <= med3(mid_p1[0], mid_p1[1], mid_p1[2]);
        hi_min_p2  <= min2(min2(hi_p1[0], hi_p1[1]), hi_p1[2]);
        kind_p2    <= kind_p1;
        centre_p2  <= centre_p1;
        // S3: final median
        med_p3    <= med3(lo_max_p2, mid_med_p2, hi_min_p2);
        kind_p3   <= kind_p2;
        centre_p3 <= centre_p2;
    end

    // S4: replace decision and output register
    always_ff @(posedge clk) begin
        if (en) begin
            dout      <= '0;
            valid_out <= 1'b0;
            fixed     <= 1'b0;
        end else begin
            valid_out <= vld_p3;
            fixed     <= 1'b0;
            if (vld_p3) begin
                if (kind_p3 == TOK_MEDIAN && abs_diff(centre_p3, med_p3) > THR) begin
                    dout  <= med_p3;
                    fixed <= 1'b1;
                end else begin
                    dout  <= centre_p3;
                end
            end
        end
    end

endmodule

// File: tb/tb_median_fix3x3.sv
// Scoreboard bench for median_fix3x3: each driven row pushes its expected
// corrected pixels and output cycle; the output monitor pops and compares.
module tb_median_fix3x3;
    import img_pkg::*;

    localparam int COL    = 8;
    localparam int THRESH = 20;

    typedef struct packed {
        logic [7:0] d;
        logic       f;
        int         c;
        int         col;
    } exp_t;

    logic       clk = 1'b0;
    logic       en;
    logic [7:0] row_top, row_mid, row_bot;
    logic       valid_in;
    logic [7:0] dout;
    logic       valid_out;
    logic       fixed;

    logic [7:0] rt [COL];
    logic [7:0] rm [COL];
    logic [7:0] rb [COL];
    exp_t       sb [$];
    exp_t       e;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    median_fix3x3 #(.WIDTH(8), .COL(COL), .THRESH(THRESH)) dut (
        .clk       (clk),
        .en        (en),
        .row_top   (row_top),
        .row_mid   (row_mid),
        .row_bot   (row_bot),
        .valid_in  (valid_in),
        .dout      (dout),
        .valid_out (valid_out),
        .fixed     (fixed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: full sort of the nine neighbours, centre kept at row edges.
    function automatic exp_t model(input int j, input int c);
        exp_t r;
        int   v [9];
        int   t, cen, med, dif;
        cen = int'(rm[j]);
        r.col = j;
        r.c   = c;
        r.d   = rm[j];
        r.f   = 1'b0;
        if (j > 0 && j < COL - 1) begin
            for (int k = 0; k < 3; k++) begin
                v[k]     = int'(rt[j - 1 + k]);
                v[3 + k] = int'(rm[j - 1 + k]);
                v[6 + k] = int'(rb[j - 1 + k]);
            end
            for (int a = 0; a < 9; a++)
                for (int b = 0; b < 8 - a; b++)
                    if (v[b] > v[b + 1]) begin
                        t = v[b]; v[b] = v[b + 1]; v[b + 1] = t;
                    end
            med = v[4];
            dif = (cen > med) ? cen - med : med - cen;
            if (dif > THRESH) begin
                r.d = 8'(med);
                r.f = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic fill(input int val);
        for (int j = 0; j < COL; j++) begin
            rt[j] = 8'(val); rm[j] = 8'(val); rb[j] = 8'(val);
        end
    endtask

    task automatic fill_rand();
        for (int j = 0; j < COL; j++) begin
            rt[j] = 8'($urandom_range(0, 255));
            rm[j] = 8'($urandom_range(0, 255));
            rb[j] = 8'($urandom_range(0, 255));
        end
    endtask

    // Called just after a rising edge; leaves valid_in high on return so rows
    // can be chained back to back.
    task automatic drive_row(input bit gaps);
        for (int j = 0; j < COL; j++) begin
            int n;
            n = gaps ? int'($urandom_range(0, 2)) : 0;
            repeat (n) begin
                valid_in = 1'b0;
                @(posedge clk); #1;
            end
            row_top = rt[j]; row_mid = rm[j]; row_bot = rb[j];
            valid_in = 1'b1;
            if (j >= 1) sb.push_back(model(j - 1, cyc + 1 + MED_LAT));
            if (j == COL - 1) sb.push_back(model(j, cyc + 2 + MED_LAT));
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        valid_in = 1'b0;
        repeat (MED_LAT + 4) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            if (sb.size() == 0) begin
                chk("extra_out", 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("dout_c%0d", e.col), int'(dout), int'(e.d));
                chk($sformatf("fixed_c%0d", e.col), int'(fixed), int'(e.f));
                chk($sformatf("cycle_c%0d", e.col), cyc, e.c);
            end
        end else if (!en) begin
            chk("fixed_idle", int'(fixed), 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        en = 1'b1; valid_in = 1'b0;
        row_top = '0; row_mid = '0; row_bot = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_fixed", int'(fixed), 0);
        en = 1'b0;

        fill(50);
        drive_row(1'b0); drain();

        fill(10); rm[3] = 8'd255;
        drive_row(1'b0); drain();

        fill(10); rm[0] = 8'd255; rm[7] = 8'd255;
        drive_row(1'b0); drain();

        fill(10); rm[2] = 8'd30; rm[5] = 8'd31;
        drive_row(1'b0); drain();

        // Partial row then reset: nothing from it may ever come out.
        fill(10);
        for (int j = 0; j < 5; j++) begin
            row_top = rt[j]; row_mid = rm[j]; row_bot = rb[j];
            valid_in = 1'b1;
            @(posedge clk); #1;
        end
        valid_in = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        chk("rst_mid_valid", int'(valid_out), 0);
        chk("rst_mid_dout", int'(dout), 0);
        repeat (8) @(posedge clk);
        #1;
        chk("rst_mid_quiet", sb.size(), 0);

        fill(40); rm[6] = 8'd200;
        drive_row(1'b0); drain();

        fill(20); rm[4] = 8'd100;
        drive_row(1'b0);
        fill(60); rm[1] = 8'd0; rt[0] = 8'd5;
        drive_row(1'b0); drain();

        repeat (4) begin
            fill_rand();
            drive_row(1'b1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
